// File: rtl/scaler.sv
// Binary scaler driven by the timer's F01 strobes: divide-by-two chain with
// per-stage rise/fall strobes, a wrap strobe and a scaler-failure watchdog.
module scaler #(
  parameter int STAGES   = 17,
  parameter int WD_LIMIT = 64
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              F01A,
  input  logic              F01B,
  output logic [STAGES-1:0] FS,
  output logic [STAGES-1:0] FS_n,
  output logic [STAGES-1:0] FA,
  output logic [STAGES-1:0] FB,
  output logic              WRAP,
  output logic              SCAFAL
);

  localparam logic [15:0]       WD_MAX  = 16'(WD_LIMIT);
  localparam logic [STAGES-1:0] CNT_ONE = STAGES'(1);

  logic [STAGES-1:0] cnt_q, cnt_d, cnt_inc;
  logic [STAGES-1:0] fa_q, fa_d;
  logic [STAGES-1:0] fb_q, fb_d;
  logic              wrap_q, wrap_d;
  logic [15:0]       wd_q, wd_d;
  logic              scafal_q, scafal_d;

  // Idle counter that stops at the alarm threshold instead of rolling over.
  function automatic logic [15:0] wd_sat_inc(input logic [15:0] wd);
    return (wd >= WD_MAX) ? WD_MAX : wd + 16'd1;
  endfunction

  always_comb begin
    cnt_inc = cnt_q + CNT_ONE;
    cnt_d   = cnt_q;
    fa_d    = '0;
    fb_d    = '0;
    wrap_d  = 1'b0;
    if (F01B) begin
      cnt_d  = cnt_inc;
      fa_d   = ~cnt_q & cnt_inc;
      fb_d   = cnt_q & ~cnt_inc;
      wrap_d = &cnt_q;
    end
    // F01A only proves the timer is alive; it never advances the count.
    wd_d     = (F01A || F01B) ? 16'd0 : wd_sat_inc(wd_q);
    scafal_d = (wd_d == WD_MAX);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      cnt_q    <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      wrap_q   <= 1'b0;
      wd_q     <= 16'd0;
      scafal_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      wrap_q   <= wrap_d;
      wd_q     <= wd_d;
      scafal_q <= scafal_d;
    end
  end

  assign FS     = cnt_q;
  assign FS_n   = ~cnt_q;
  assign FA     = fa_q;
  assign FB     = fb_q;
  assign WRAP   = wrap_q;
  assign SCAFAL = scafal_q;

endmodule
